hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Parametrised pipeline hazard and stall controller for the RV32IM 5-stage core, the successor to the single-cycle load-use/branch hazard unit. It adds three things: a multi-cycle divider stall sequenced by an internal counter, a data-memory wait freeze, and per-stage enable/flush control for all four pipeline registers. Optional saturating performance counters are also provided. It sits beside the ID/EX stages and drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB control.

## Interface
- DIV_CYCLES, 33: total divider latency in cycles, counted from the cycle the div/rem instruction first sits in EX; must be >= 2
- PERF_W, 32: width of the performance counters
- clk  input  1  core clock
- rst_n  input  1  synchronous reset, active-low
- id_rs1, id_rs2  input  5  source registers of the instruction in ID
- id_opcode  input  7  opcode of the instruction in ID
- ex_rd  input  5  destination register of the instruction in EX
- ex_load_inst  input  1  instruction in EX is a load
- ex_div_start  input  1  instruction in EX is div/divu/rem/remu
- jump_branch_taken  input  1  redirect resolved in EX
- dmem_stall  input  1  data memory not ready; whole pipeline must freeze
- pc_en, if_id_en, id_ex_en, ex_mem_en  output  1  register enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  output  1  bubble inserts; flush overrides enable in the target register
- div_busy  output  1  state is DIV_BUSY
- div_done  output  1  one-cycle pulse; divider result valid, EX may advance
- stall_cycles, flush_events  output  PERF_W  performance counters

## Operation
- rs1 is used by these opcodes: R (0110011), I (0010011), LOAD (0000011), JALR (1100111), S (0100011), B (1100011).
- rs2 is used by these opcodes: R, S, B.
- load_use = ex_load_inst & ex_rd!=0 & ((id_rs1==ex_rd & rs1_used) | (id_rs2==ex_rd & rs2_used)).
- FSM state IDLE:
  - ex_div_start with dmem_stall=0: load cnt=DIV_CYCLES-1 and go to DIV_BUSY.
  - If DIV_CYCLES==2, go to DIV_BUSY with cnt=1; the next cycle is the done cycle.
- FSM state DIV_BUSY:
  - cnt decrements every cycle while cnt>1.
  - At cnt==1 with dmem_stall=0: div_done=1, no div stall, go to IDLE.
  - At cnt==1 with dmem_stall=1: hold cnt=1, stay in DIV_BUSY.
  - ex_div_start is ignored while in DIV_BUSY.
- Output actions, highest priority first; outputs not listed take their defaults (all en=1, all flush=0):
  1. dmem_stall: pc_en, if_id_en, id_ex_en, ex_mem_en =0; mem_wb_flush=1.
  2. div stall (IDLE&ex_div_start, or DIV_BUSY&cnt>1): pc_en, if_id_en, id_ex_en =0; ex_mem_flush=1.
  3. jump_branch_taken: if_id_flush=1, id_ex_flush=1, pc_en=1.
  4. load_use: pc_en=0, if_id_en=0, id_ex_flush=1.
- A branch and a div cannot both occupy EX; if both are asserted, the div stall wins.
- A branch held during dmem_stall takes effect on the first cycle with dmem_stall=0.
- Reset mid-divide aborts the divide: state returns to IDLE and cnt to 0.

## Timing
- During rst_n=0 and in the first cycle after reset:
  - state IDLE, cnt 0
  - all enables 1, all flushes 0
  - div_busy 0, div_done 0
  - stall_cycles 0, flush_events 0 (when compiled in)
- All outputs except div_busy and the counters are combinational from inputs and state, valid in the same cycle.
- Divide: ex_div_start first seen at cycle T. Stall covers T..T+DIV_CYCLES-2, i.e. DIV_CYCLES-1 cycles. div_done is high at T+DIV_CYCLES-1, and EX advances at the end of that cycle. Each cycle of dmem_stall during the divide extends this by one cycle.
- Load-use costs 1 bubble; a taken branch costs 2 flushed slots.
- cnt width is $clog2(DIV_CYCLES+1).

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments in every cycle with pc_en=0.
  - flush_events increments in every cycle where rule 3 is applied.
  - Both saturate at 2^PERF_W-1 and clear on reset.
- HAZARD_PERF_CNT_EN undefined: both outputs tied to 0 and no counter registers are built.

## Test plan
- Load-use: ex_load_inst=1, ex_rd=5, id_opcode=0110011, id_rs2=5 -> pc_en=0, if_id_en=0, id_ex_flush=1 for 1 cycle.
- Load to x0, and I-type ignoring rs2: ex_rd=0 with id_rs1=0, then ex_rd=7 with id_opcode=0010011, id_rs2=7 -> no stall in either case.
- Divide with DIV_CYCLES=4: ex_div_start held high from T.
  - pc_en=0 at T..T+2.
  - div_done=1 and pc_en=1 at T+3.
  - div_busy=1 at T+1..T+3, back to IDLE at T+4.
- dmem_stall=1 for 2 cycles arriving at cnt==1 -> div_done delayed 2 cycles; mem_wb_flush=1 and ex_mem_en=0 for those cycles.
- jump_branch_taken=1 concurrent with load_use -> if_id_flush=1, id_ex_flush=1, pc_en=1; flush_events +1 when HAZARD_PERF_CNT_EN is defined.
- rst_n=0 at T+1 of a divide -> the next cycle has div_busy=0 and all enables 1; a fresh ex_div_start then restarts the full DIV_CYCLES sequence.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use, branch flush, multi-cycle divide stall and dmem freeze.
// Optional saturating perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
    parameter int unsigned DIV_CYCLES = 33,
    parameter int unsigned PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [6:0]        id_opcode,
    input  logic [4:0]        ex_rd,
    input  logic              ex_load_inst,
    input  logic              ex_div_start,
    input  logic              jump_branch_taken,
    input  logic              dmem_stall,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              mem_wb_flush,
    output logic              div_busy,
    output logic              div_done,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_events
);

    localparam int unsigned      CNT_W    = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;

    typedef enum logic {
        IDLE     = 1'b0,
        DIV_BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             busy_q;
    logic             rs1_used;
    logic             rs2_used;
    logic             load_use;
    logic             div_stall;

    // Source-operand usage decode for the instruction in ID
    assign rs1_used = (id_opcode == OP_R) || (id_opcode == OP_I) || (id_opcode == OP_LOAD) ||
                      (id_opcode == OP_JALR) || (id_opcode == OP_S) || (id_opcode == OP_B);
    assign rs2_used = (id_opcode == OP_R) || (id_opcode == OP_S) || (id_opcode == OP_B);

    assign load_use = ex_load_inst && (ex_rd != 5'd0) &&
                      (((id_rs1 == ex_rd) && rs1_used) || ((id_rs2 == ex_rd) && rs2_used));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            busy_q <= (state_next == DIV_BUSY);
        end
    end

    // Divide sequencing plus prioritised enable/flush selection
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        div_stall    = 1'b0;
        div_done     = 1'b0;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;

        // A dmem freeze holds the divide sequence in place for that cycle
        case (state)
            IDLE: begin
                if (ex_div_start) begin
                    div_stall = 1'b1;
                    if (!dmem_stall) begin
                        state_next = DIV_BUSY;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            DIV_BUSY: begin
                if (cnt > CNT_ONE) begin
                    div_stall = 1'b1;
                    if (!dmem_stall) begin
                        cnt_next = cnt - CNT_ONE;
                    end
                end else if (!dmem_stall) begin
                    div_done   = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        if (dmem_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (div_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (jump_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            pc_en       = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end

        // Reset forces the pipeline controls to their free-running defaults
        if (!rst_n) begin
            div_done     = 1'b0;
            pc_en        = 1'b1;
            if_id_en     = 1'b1;
            id_ex_en     = 1'b1;
            ex_mem_en    = 1'b1;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b0;
            mem_wb_flush = 1'b0;
        end
    end

    assign div_busy = busy_q && rst_n;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_q;
    logic [PERF_W-1:0] flush_q;
    logic              flush_apply;

    assign flush_apply = rst_n && jump_branch_taken && !dmem_stall && !div_stall;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && (stall_q != {PERF_W{1'b1}})) begin
                stall_q <= stall_q + PERF_W'(1);
            end
            if (flush_apply && (flush_q != {PERF_W{1'b1}})) begin
                flush_q <= flush_q + PERF_W'(1);
            end
        end
    end

    assign stall_cycles = rst_n ? stall_q : '0;
    assign flush_events = rst_n ? flush_q : '0;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed hazard scenarios followed by random traffic.
module tb_hazard_stall_ctrl;

    localparam int unsigned DIV_CYCLES = 4;
    localparam int unsigned PERF_W     = 32;
    localparam longint      PERF_MAX   = (64'sd1 <<< PERF_W) - 1;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [4:0]        id_rs1, id_rs2, ex_rd;
    logic [6:0]        id_opcode;
    logic              ex_load_inst, ex_div_start, jump_branch_taken, dmem_stall;
    logic              pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic              if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic              div_busy, div_done;
    logic [PERF_W-1:0] stall_cycles, flush_events;

    typedef struct {
        logic   pc_en, if_id_en, id_ex_en, ex_mem_en;
        logic   if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
        logic   div_busy, div_done;
        longint stall, flush;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    bit     m_busy = 0;
    int     m_left = 0;
    longint m_stall = 0;
    longint m_flush = 0;
    logic [6:0] ops [8];

    hazard_stall_ctrl #(.DIV_CYCLES(DIV_CYCLES), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_opcode(id_opcode),
        .ex_rd(ex_rd), .ex_load_inst(ex_load_inst), .ex_div_start(ex_div_start),
        .jump_branch_taken(jump_branch_taken), .dmem_stall(dmem_stall),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .div_busy(div_busy), .div_done(div_done),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive, predict from the rules, push, advance the model
    task automatic step(input logic r, input logic ld, input logic ds, input logic br,
                        input logic dm, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [6:0] op);
        exp_t e;
        bit   rs1u, rs2u, lu, dstall, fl;
        @(posedge clk);
        #1;
        rst_n = r; ex_load_inst = ld; ex_div_start = ds; jump_branch_taken = br;
        dmem_stall = dm; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd; id_opcode = op;

        rs1u = (op inside {OP_R, OP_I, OP_LOAD, OP_JALR, OP_S, OP_B});
        rs2u = (op inside {OP_R, OP_S, OP_B});
        lu   = ld && (rd != 0) && (((rs1 == rd) && rs1u) || ((rs2 == rd) && rs2u));
        e.pc_en = 1; e.if_id_en = 1; e.id_ex_en = 1; e.ex_mem_en = 1;
        e.if_id_flush = 0; e.id_ex_flush = 0; e.ex_mem_flush = 0; e.mem_wb_flush = 0;
        e.div_busy = r && m_busy;
        e.div_done = 0;
        fl = 0;
        if (r) begin
            dstall = (!m_busy && ds) || (m_busy && m_left > 1);
            e.div_done = m_busy && (m_left == 1) && !dm;
            if (dm) begin
                e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0; e.ex_mem_en = 0; e.mem_wb_flush = 1;
            end else if (dstall) begin
                e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0; e.ex_mem_flush = 1;
            end else if (br) begin
                e.if_id_flush = 1; e.id_ex_flush = 1; fl = 1;
            end else if (lu) begin
                e.pc_en = 0; e.if_id_en = 0; e.id_ex_flush = 1;
            end
        end
`ifdef HAZARD_PERF_CNT_EN
        e.stall = r ? m_stall : 0;
        e.flush = r ? m_flush : 0;
`else
        e.stall = 0;
        e.flush = 0;
`endif
        sb.push_back(e);

        if (!r) begin
            m_busy = 0; m_left = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!e.pc_en && m_stall < PERF_MAX) m_stall++;
            if (fl && m_flush < PERF_MAX) m_flush++;
            // m_left counts the non-frozen cycles remaining before the result is ready
            if (!m_busy) begin
                if (ds && !dm) begin
                    m_busy = 1;
                    m_left = DIV_CYCLES - 1;
                end
            end else if (!dm) begin
                m_left--;
                if (m_left == 0) m_busy = 0;
            end
        end
    endtask

    task automatic idle_step(input logic r);
        step(r, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, OP_LUI);
    endtask

    task automatic div_step(input logic ds, input logic dm);
        step(1, 0, ds, 0, dm, 5'd1, 5'd2, 5'd3, OP_R);
    endtask

    // Monitor: every cycle presents a full output set, compared at the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc_en", pc_en, e.pc_en);
                chk("if_id_en", if_id_en, e.if_id_en);
                chk("id_ex_en", id_ex_en, e.id_ex_en);
                chk("ex_mem_en", ex_mem_en, e.ex_mem_en);
                chk("if_id_flush", if_id_flush, e.if_id_flush);
                chk("id_ex_flush", id_ex_flush, e.id_ex_flush);
                chk("ex_mem_flush", ex_mem_flush, e.ex_mem_flush);
                chk("mem_wb_flush", mem_wb_flush, e.mem_wb_flush);
                chk("div_busy", div_busy, e.div_busy);
                chk("div_done", div_done, e.div_done);
                chk("stall_cycles", longint'(stall_cycles), e.stall);
                chk("flush_events", longint'(flush_events), e.flush);
            end
        end
    end

    initial begin
        ops = '{OP_R, OP_I, OP_LOAD, OP_JALR, OP_S, OP_B, OP_LUI, OP_JAL};
        rst_n = 0; ex_load_inst = 0; ex_div_start = 0; jump_branch_taken = 0; dmem_stall = 0;
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_opcode = OP_LUI;

        idle_step(0);
        idle_step(0);
        idle_step(1);

        // Load-use on rs2 of an R-type, then loads that must not stall
        step(1, 1, 0, 0, 0, 5'd1, 5'd5, 5'd5, OP_R);
        step(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, OP_R);
        step(1, 1, 0, 0, 0, 5'd1, 5'd7, 5'd7, OP_I);
        idle_step(1);

        // Divide with start held high through and past completion
        repeat (DIV_CYCLES) div_step(1, 0);
        div_step(0, 0);
        div_step(0, 0);

        // Divide with a two-cycle dmem freeze landing on the final count
        div_step(1, 0);
        repeat (DIV_CYCLES - 2) div_step(0, 0);
        div_step(0, 1);
        div_step(0, 1);
        div_step(0, 0);
        div_step(0, 0);

        // Branch concurrent with a load-use, and a branch held through dmem freeze
        step(1, 1, 0, 1, 0, 5'd1, 5'd5, 5'd5, OP_R);
        step(1, 0, 0, 1, 1, 5'd1, 5'd2, 5'd3, OP_R);
        step(1, 0, 0, 1, 0, 5'd1, 5'd2, 5'd3, OP_R);
        idle_step(1);

        // Reset mid-divide, then a fresh full divide
        div_step(1, 0);
        step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, OP_LUI);
        idle_step(1);
        repeat (DIV_CYCLES) div_step(1, 0);
        div_step(0, 0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) != 0),
                 ($urandom_range(2) == 0),
                 ($urandom_range(5) == 0),
                 ($urandom_range(4) == 0),
                 ($urandom_range(6) == 0),
                 5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
                 ops[$urandom_range(7)]);
        end
        idle_step(1);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
